// File: rtl/fcounter_trim_ctrl.sv
`default_nettype none
// ============================================================================
// fcounter_trim_ctrl : SAR oscillator trim sequenced over the fcounter handshake
// Rev 1.0
// ============================================================================
module fcounter_trim_ctrl #(
  parameter int N        = 8,
  parameter int TRIM_W   = 6,
  parameter int WINDOW   = 320,
  parameter int TIMEOUT  = 1023,
  parameter int POLARITY = 0,
  parameter int TRIM_RST = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic [N-1:0]      target,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TRIM_W-1:0] trim,
  output logic [N-1:0]      meas,
  output logic              fcounter_ce,
  output logic              fcounter_som,
  input  logic              fcounter_eom,
  input  logic              fcounter_rdy,
  input  logic [N-1:0]      fcounter_adata
);

  localparam int c_WCNT_W = $clog2(WINDOW + 1);
  localparam int c_TCNT_W = $clog2(TIMEOUT + 1);
  localparam int c_BIT_W  = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  localparam logic [c_WCNT_W-1:0] c_WCNT_MAX  = {c_WCNT_W{1'b1}};
  localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(WINDOW - 1);
  localparam logic [c_TCNT_W-1:0] c_TCNT_MAX  = {c_TCNT_W{1'b1}};
  localparam logic [c_TCNT_W-1:0] c_TCNT_LIM  = c_TCNT_W'(TIMEOUT);
  localparam logic [c_BIT_W-1:0]  c_BIT_TOP   = c_BIT_W'(TRIM_W - 1);
  localparam logic [TRIM_W-1:0]   c_TRIM_RST  = TRIM_W'(TRIM_RST);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SETBIT    = 4'd1,
    S_ARM       = 4'd2,
    S_START     = 4'd3,
    S_WAIT_BUSY = 4'd4,
    S_WINDOW    = 4'd5,
    S_STOP      = 4'd6,
    S_WAIT_EOM  = 4'd7,
    S_ACK       = 4'd8,
    S_DECIDE    = 4'd9
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_BIT_W-1:0]  r_bit;
  logic [TRIM_W-1:0]   r_trim;
  logic [N-1:0]        r_meas;
  logic [N-1:0]        r_target;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_som;
  logic                r_ce;
  logic [c_TCNT_W-1:0] r_tcnt;
  logic [c_WCNT_W-1:0] r_wcnt;

  logic w_accept;
  logic w_abort;
  logic w_finish;
  logic w_capture;
  logic w_timeout;
  logic w_clr_bit;

  assign w_timeout = (r_tcnt >= c_TCNT_LIM);

  // A probe that overshoots the target drops the bit; equality keeps it.
  assign w_clr_bit = (POLARITY == 0) ? (r_meas > r_target) : (r_meas < r_target);

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_abort   = 1'b0;
    w_finish  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_SETBIT;
        end
      end
      S_SETBIT: begin
        if (fcounter_rdy)   w_next  = S_ARM;
        else if (w_timeout) w_abort = 1'b1;
      end
      S_ARM:   w_next = S_START;
      S_START: w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!fcounter_eom)  w_next  = S_WINDOW;
        else if (w_timeout) w_abort = 1'b1;
      end
      S_WINDOW: begin
        if (r_wcnt >= c_WCNT_LAST) w_next = S_STOP;
      end
      S_STOP: w_next = S_WAIT_EOM;
      S_WAIT_EOM: begin
        if (fcounter_eom) begin
          w_capture = 1'b1;
          w_next    = S_ACK;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      S_ACK: w_next = S_DECIDE;
      S_DECIDE: begin
        if (r_bit == '0) begin
          w_finish = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_next = S_SETBIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state  <= S_IDLE;
      r_bit    <= c_BIT_TOP;
      r_trim   <= c_TRIM_RST;
      r_meas   <= '0;
      r_target <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_som    <= 1'b0;
      r_ce     <= 1'b0;
      r_tcnt   <= '0;
      r_wcnt   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_finish | w_abort;
      r_ce    <= (w_next == S_START) || (w_next == S_STOP) || (w_next == S_ACK);
      r_som   <= (w_next == S_ARM) || (w_next == S_START) || (w_next == S_WAIT_BUSY);

      if (w_next != r_state)      r_tcnt <= '0;
      else if (r_tcnt != c_TCNT_MAX) r_tcnt <= r_tcnt + c_TCNT_W'(1);

      // Gate time is measured from the start strobe, independent of WAIT_BUSY length.
      if (r_state == S_START)        r_wcnt <= c_WCNT_W'(1);
      else if (r_wcnt != c_WCNT_MAX) r_wcnt <= r_wcnt + c_WCNT_W'(1);

      if (w_accept) begin
        r_busy   <= 1'b1;
        r_error  <= 1'b0;
        r_target <= target;
        r_trim   <= '0;
        r_bit    <= c_BIT_TOP;
      end

      if (r_state == S_SETBIT) r_trim[r_bit] <= 1'b1;

      if (w_capture) r_meas <= fcounter_adata;

      if (r_state == S_DECIDE) begin
        if (w_clr_bit) r_trim[r_bit] <= 1'b0;
        if (r_bit != '0) r_bit <= r_bit - c_BIT_W'(1);
        if (w_finish)    r_busy <= 1'b0;
      end

      if (w_abort) begin
        r_trim  <= c_TRIM_RST;
        r_error <= 1'b1;
        r_busy  <= 1'b0;
        r_bit   <= c_BIT_TOP;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign trim         = r_trim;
  assign meas         = r_meas;
  assign fcounter_ce  = r_ce;
  assign fcounter_som = r_som;

endmodule
`default_nettype wire
